// File: rtl/linear_interpolator_pkg.sv
// Shared settings for the linear interpolator: sample and factor widths, fixed-point format, FSM states.
// Define LINEAR_INTERPOLATOR_ROUND_EN to round outputs to nearest instead of truncating.
package package_settings;

    localparam int SIZE_DATA       = 16;
    localparam int SIZE_WINDOW     = 7;
    localparam int SIZE_FRAC       = 6;
    localparam int SIZE_MAX_FACTOR = 64;
    localparam int SIZE_SHIFT      = $clog2(SIZE_MAX_FACTOR);
    localparam int SIZE_CNT        = $clog2(SIZE_MAX_FACTOR) + 1;
    localparam int SIZE_ACC        = SIZE_DATA + SIZE_FRAC + 1;

    typedef enum logic {IDLE, RUN} interp_state_t;

    typedef logic signed [SIZE_ACC-1:0] acc_t;

    function automatic logic [SIZE_CNT-1:0] factor_from_shift(input logic [SIZE_SHIFT-1:0] k);
        return SIZE_CNT'(1) << k;
    endfunction

endpackage

// File: rtl/linear_interpolator_if.sv
// Sample-in / sample-out stream bundle of the linear interpolator.
// The master side drives samples and factor; the slave side is the interpolator.
interface linear_interpolator_if;
    import package_settings::*;

    logic signed [SIZE_DATA-1:0]   input_data;
    logic                          input_valid;
    logic                          input_ready;
    logic        [SIZE_WINDOW-1:0] factor;
    logic signed [SIZE_DATA-1:0]   output_data;
    logic                          output_valid;
    logic                          output_ready;

    modport master (
        output input_data, input_valid, factor, output_ready,
        input  input_ready, output_data, output_valid
    );

    modport slave (
        input  input_data, input_valid, factor, output_ready,
        output input_ready, output_data, output_valid
    );

endinterface

// File: rtl/linear_interpolator_factor_decode.sv
// Upsample factor decoder: maps L in {1,2,4,...,64} to k = log2(L).
// Anything else is flagged illegal and treated as L = 1.
module interp_factor_decode
    import package_settings::*;
(
    input  logic [SIZE_WINDOW-1:0] factor,
    output logic [SIZE_SHIFT-1:0]  k,
    output logic                   legal
);

    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        k     = '0;
        legal = 1'b1;
        case (factor)
            SIZE_WINDOW'(1):  k = SIZE_SHIFT'(0);
            SIZE_WINDOW'(2):  k = SIZE_SHIFT'(1);
            SIZE_WINDOW'(4):  k = SIZE_SHIFT'(2);
            SIZE_WINDOW'(8):  k = SIZE_SHIFT'(3);
            SIZE_WINDOW'(16): k = SIZE_SHIFT'(4);
            SIZE_WINDOW'(32): k = SIZE_SHIFT'(5);
            SIZE_WINDOW'(64): k = SIZE_SHIFT'(6);
            default:          legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/linear_interpolator.sv
// Upsampling linear interpolator: each accepted sample yields L beats ramping from the previous sample.
// Define LINEAR_INTERPOLATOR_ROUND_EN for round-to-nearest output; default build truncates.
module linear_interpolator
    import package_settings::*;
(
    input logic                  clk,
    input logic                  reset,
    linear_interpolator_if.slave bus
);

    interp_state_t               state_q, state_d;
    logic signed [SIZE_DATA-1:0] prev_q,  prev_d;
    acc_t                        acc_q,   acc_d;
    acc_t                        step_q,  step_d;
    logic [SIZE_SHIFT-1:0]       k_q,     k_d;
    logic [SIZE_CNT-1:0]         cnt_q,   cnt_d;

    logic [SIZE_SHIFT-1:0]       dec_k;
    logic                        dec_legal;

    logic                        out_xfer;
    logic                        last_beat;
    logic                        in_accept;
    logic signed [SIZE_DATA:0]   delta;
    acc_t                        delta_ext;
    acc_t                        prev_ext;
    acc_t                        step_new;
    acc_t                        acc_out;
    logic                        unused_bits;

    interp_factor_decode u_decode (
        .factor (bus.factor),
        .k      (dec_k),
        .legal  (dec_legal)
    );

    assign last_beat       = (cnt_q == factor_from_shift(k_q));
    assign out_xfer        = bus.output_valid && bus.output_ready;
    // Ready on the final beat's transfer lets L=1 run back to back.
    assign bus.input_ready = (state_q == IDLE) || (out_xfer && last_beat);
    assign in_accept       = bus.input_valid && bus.input_ready;

    assign delta     = {bus.input_data[SIZE_DATA-1], bus.input_data} - {prev_q[SIZE_DATA-1], prev_q};
    assign delta_ext = {{(SIZE_ACC-SIZE_DATA-1){delta[SIZE_DATA]}}, delta};
    assign prev_ext  = {{(SIZE_ACC-SIZE_DATA){prev_q[SIZE_DATA-1]}}, prev_q};
    // delta*64/L is an exact integer for every legal L, so beat L lands on x with no drift.
    assign step_new  = delta_ext <<< (SIZE_SHIFT'(SIZE_FRAC) - dec_k);

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        acc_d   = acc_q;
        step_d  = step_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        if (in_accept) begin
            state_d = RUN;
            prev_d  = bus.input_data;
            k_d     = dec_k;
            step_d  = step_new;
            acc_d   = (prev_ext <<< SIZE_FRAC) + step_new;
            cnt_d   = SIZE_CNT'(1);
        end else if (out_xfer) begin
            if (last_beat) begin
                state_d = IDLE;
            end else begin
                acc_d = acc_q + step_q;
                cnt_d = cnt_q + SIZE_CNT'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            prev_q  <= '0;
            acc_q   <= '0;
            step_q  <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q <= state_d;
            prev_q  <= prev_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef LINEAR_INTERPOLATOR_ROUND_EN
    assign acc_out = acc_q + acc_t'(1 << (SIZE_FRAC - 1));
`else
    assign acc_out = acc_q;
`endif

    assign bus.output_data  = acc_out[SIZE_DATA+SIZE_FRAC-1:SIZE_FRAC];
    assign bus.output_valid = (state_q == RUN);

    assign unused_bits = ^{acc_out[SIZE_ACC-1], acc_out[SIZE_FRAC-1:0], dec_legal};

endmodule

// File: tb/tb_linear_interpolator.sv
// Directed testbench for linear_interpolator: ramps, rounding, throughput, backpressure,
// illegal factors, factor hold and reset mid-burst, with hand-computed expectations.
module tb_linear_interpolator;
    import package_settings::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    linear_interpolator_if bus();

    linear_interpolator dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset            = 1'b1;
        bus.input_valid  = 1'b0;
        bus.input_data   = '0;
        bus.factor       = SIZE_WINDOW'(1);
        bus.output_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_tests++;
        if (bus.output_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b expected 0", bus.output_valid);
        end
        n_tests++;
        if (bus.output_data !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %0d expected 0", bus.output_data);
        end
        n_tests++;
        if (bus.input_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 1", bus.input_ready);
        end
    endtask

    task automatic test_ramp();
        int exp_tab [8];
        logic signed [SIZE_DATA-1:0] exp_d;
        logic exp_r;
        exp_tab = '{2, 4, 6, 8, 6, 4, 2, 0};
        apply_reset();
        bus.factor       = SIZE_WINDOW'(4);
        bus.input_data   = 16'sd8;
        bus.input_valid  = 1'b1;
        bus.output_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) bus.input_data = 16'sd0;
            if (i == 7) bus.input_valid = 1'b0;
            #1;
            exp_d = SIZE_DATA'(exp_tab[i]);
            exp_r = (i == 3) || (i == 7);
            n_tests++;
            if (bus.output_valid !== 1'b1 || bus.output_data !== exp_d) begin
                n_fail++;
                $display("FAIL ramp_beat %0d: got valid=%b data=%0d expected valid=1 data=%0d",
                         i, bus.output_valid, bus.output_data, exp_d);
            end
            n_tests++;
            if (bus.input_ready !== exp_r) begin
                n_fail++;
                $display("FAIL ramp_ready %0d: got %b expected %b", i, bus.input_ready, exp_r);
            end
        end
        tick();
        #1;
        n_tests++;
        if (bus.output_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ramp_idle: got valid=%b expected 0", bus.output_valid);
        end
    endtask

    task automatic test_negative_round();
        logic signed [SIZE_DATA-1:0] exp_d [2];
`ifdef LINEAR_INTERPOLATOR_ROUND_EN
        exp_d[0] = -16'sd1;
`else
        exp_d[0] = -16'sd2;
`endif
        exp_d[1] = -16'sd3;
        apply_reset();
        bus.factor      = SIZE_WINDOW'(2);
        bus.input_data  = -16'sd3;
        bus.input_valid = 1'b1;
        tick();
        bus.input_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_tests++;
            if (bus.output_valid !== 1'b1 || bus.output_data !== exp_d[i]) begin
                n_fail++;
                $display("FAIL negative_beat %0d: got valid=%b data=%0d expected valid=1 data=%0d",
                         i, bus.output_valid, bus.output_data, exp_d[i]);
            end
            tick();
        end
        #1;
        n_tests++;
        if (bus.output_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL negative_idle: got valid=%b expected 0", bus.output_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic signed [SIZE_DATA-1:0] exp_d;
        bus.factor       = SIZE_WINDOW'(1);
        bus.output_ready = 1'b1;
        bus.input_data   = 16'sd1;
        bus.input_valid  = 1'b1;
        #1;
        n_tests++;
        if (bus.input_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready_start: got %b expected 1", bus.input_ready);
        end
        for (int i = 1; i <= 10; i++) begin
            tick();
            bus.input_data = SIZE_DATA'(i + 1);
            if (i == 10) bus.input_valid = 1'b0;
            #1;
            exp_d = SIZE_DATA'(i);
            n_tests++;
            if (bus.output_valid !== 1'b1 || bus.output_data !== exp_d || bus.input_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_beat %0d: got valid=%b data=%0d ready=%b expected valid=1 data=%0d ready=1",
                         i, bus.output_valid, bus.output_data, bus.input_ready, exp_d);
            end
        end
        tick();
        #1;
        n_tests++;
        if (bus.output_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: got valid=%b expected 0", bus.output_valid);
        end
    endtask

    task automatic test_backpressure();
        int beat;
        int cyc;
        logic signed [SIZE_DATA-1:0] exp_d;
        apply_reset();
        bus.factor      = SIZE_WINDOW'(8);
        bus.input_data  = 16'sd64;
        bus.input_valid = 1'b1;
        tick();
        bus.input_valid = 1'b0;
        beat = 1;
        cyc  = 0;
        while (beat <= 8 && cyc < 40) begin
            bus.output_ready = (cyc % 3 == 0);
            #1;
            exp_d = SIZE_DATA'(8 * beat);
            n_tests++;
            if (bus.output_valid !== 1'b1 || bus.output_data !== exp_d) begin
                n_fail++;
                $display("FAIL backpressure_cycle %0d: got valid=%b data=%0d expected valid=1 data=%0d",
                         cyc, bus.output_valid, bus.output_data, exp_d);
            end
            if (bus.output_ready) beat++;
            cyc++;
            tick();
        end
        bus.output_ready = 1'b1;
        n_tests++;
        if (beat <= 8) begin
            n_fail++;
            $display("FAIL backpressure_budget: got %0d beats expected 8 within 40 cycles", beat - 1);
        end
        #1;
        n_tests++;
        if (bus.output_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_idle: got valid=%b expected 0", bus.output_valid);
        end
    endtask

    task automatic test_illegal_factor();
        bus.output_ready = 1'b1;
        bus.factor       = SIZE_WINDOW'(3);
        bus.input_data   = 16'sd5;
        bus.input_valid  = 1'b1;
        tick();
        bus.factor     = SIZE_WINDOW'(0);
        bus.input_data = 16'sd7;
        #1;
        n_tests++;
        if (bus.output_valid !== 1'b1 || bus.output_data !== 16'sd5 || bus.input_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_f3: got valid=%b data=%0d ready=%b expected valid=1 data=5 ready=1",
                     bus.output_valid, bus.output_data, bus.input_ready);
        end
        tick();
        bus.input_valid = 1'b0;
        #1;
        n_tests++;
        if (bus.output_valid !== 1'b1 || bus.output_data !== 16'sd7) begin
            n_fail++;
            $display("FAIL illegal_f0: got valid=%b data=%0d expected valid=1 data=7",
                     bus.output_valid, bus.output_data);
        end
        tick();
        #1;
        n_tests++;
        if (bus.output_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_idle: got valid=%b expected 0", bus.output_valid);
        end
    endtask

    task automatic test_factor_hold();
        logic signed [SIZE_DATA-1:0] exp_d [2];
        exp_d[0] = 16'sd8;
        exp_d[1] = 16'sd9;
        bus.factor      = SIZE_WINDOW'(2);
        bus.input_data  = 16'sd9;
        bus.input_valid = 1'b1;
        tick();
        bus.input_valid = 1'b0;
        bus.factor      = SIZE_WINDOW'(64);
        for (int i = 0; i < 2; i++) begin
            #1;
            n_tests++;
            if (bus.output_valid !== 1'b1 || bus.output_data !== exp_d[i]) begin
                n_fail++;
                $display("FAIL factor_hold_beat %0d: got valid=%b data=%0d expected valid=1 data=%0d",
                         i, bus.output_valid, bus.output_data, exp_d[i]);
            end
            tick();
        end
        #1;
        n_tests++;
        if (bus.output_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL factor_hold_idle: got valid=%b expected 0", bus.output_valid);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic signed [SIZE_DATA-1:0] exp_d;
        apply_reset();
        bus.factor      = SIZE_WINDOW'(64);
        bus.input_data  = 16'sd640;
        bus.input_valid = 1'b1;
        tick();
        bus.input_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            #1;
            exp_d = SIZE_DATA'(10 * i);
            n_tests++;
            if (bus.output_valid !== 1'b1 || bus.output_data !== exp_d) begin
                n_fail++;
                $display("FAIL midreset_pre_beat %0d: got valid=%b data=%0d expected valid=1 data=%0d",
                         i, bus.output_valid, bus.output_data, exp_d);
            end
            if (i < 10) tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_tests++;
        if (bus.output_valid !== 1'b0 || bus.output_data !== '0 || bus.input_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_clear: got valid=%b data=%0d ready=%b expected valid=0 data=0 ready=1",
                     bus.output_valid, bus.output_data, bus.input_ready);
        end
        bus.input_data  = 16'sd64;
        bus.input_valid = 1'b1;
        tick();
        bus.input_valid = 1'b0;
        for (int i = 1; i <= 64; i++) begin
            #1;
            exp_d = SIZE_DATA'(i);
            n_tests++;
            if (bus.output_valid !== 1'b1 || bus.output_data !== exp_d) begin
                n_fail++;
                $display("FAIL midreset_post_beat %0d: got valid=%b data=%0d expected valid=1 data=%0d",
                         i, bus.output_valid, bus.output_data, exp_d);
            end
            tick();
        end
        #1;
        n_tests++;
        if (bus.output_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_idle: got valid=%b expected 0", bus.output_valid);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_negative_round();
        test_back_to_back();
        test_backpressure();
        test_illegal_factor();
        test_factor_hold();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/linear_interpolator.md
# linear_interpolator

Upsampling linear interpolator: accepts one signed sample per input handshake and emits L output samples stepping linearly from the previous accepted sample to the new one, with L = 1,2,4,8,16,32,64. It is the expanding counterpart of the team's power-of-two moving-average smoother. It sits on the synthesis/output side of the sample pipeline and uses the same SIZE_DATA sample format and SIZE_WINDOW factor encoding.

## Interface
- SIZE_DATA, default 16 (package_settings): sample width, signed two's complement.
- SIZE_WINDOW, default 7 (package_settings): width of the factor port.
- clk  input  1  clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- input_data  input  SIZE_DATA  new sample x[n], signed.
- input_valid  input  1  input_data valid.
- input_ready  output  1  block can accept a sample this cycle.
- factor  input  SIZE_WINDOW  upsample factor L; legal values 1,2,4,8,16,32,64.
- output_data  output  SIZE_DATA  interpolated sample, signed.
- output_valid  output  1  output_data valid.
- output_ready  input  1  downstream accepts output this cycle.

## Operation
- Sample transfer happens on an edge with input_valid && input_ready.
- Output transfer happens on an edge with output_valid && output_ready.
- State machine:
  - IDLE: no burst pending; input_ready=1.
  - RUN: burst of L beats in progress; counter cnt counts 1..L.
- factor is sampled only on input accept and held for the whole burst.
  - It decodes to shift k = log2(L).
  - Illegal values (0, non-power-of-two, >64) decode to L=1, k=0.
- Arithmetic uses F=6 fractional bits. Register prev (SIZE_DATA) resets to 0.
- On accept:
  - delta = x - prev, computed at SIZE_DATA+1 bits signed.
  - step = delta <<< (6-k), signed.
  - acc = (prev <<< 6) + step, width SIZE_DATA+7 signed.
  - prev <= x; cnt <= 1.
- Each output beat: output_data = acc >>> 6 (arithmetic, truncation toward -inf).
- On each output transfer with cnt<L: acc += step; cnt++.
- Beat i is exactly prev_old + delta*i/L, truncated. Beat L equals x exactly, so there is no drift. Results always lie between prev_old and x, so no saturation is required.
- On the transfer of beat L:
  - If a new input is accepted the same cycle, the block stays in RUN with a new burst.
  - Otherwise it goes to IDLE.
- input_ready = (state==IDLE) || (output_valid && output_ready && cnt==L). This is a combinational path from output_ready, and it is required for full throughput at L=1.

## Timing
- Reset values: output_data=0, output_valid=0, input_ready=1 (state IDLE), prev=0, cnt=0, acc=0.
- Latency: sample accepted at edge n gives first beat valid after edge n (output_valid=1 in cycle n+1).
- Throughput:
  - One output beat per cycle when output_ready=1.
  - One input per L cycles.
  - L=1 sustains one sample per cycle back to back.
- Backpressure: while output_valid && !output_ready, output_data and output_valid hold stable and acc/cnt do not advance.
- output_valid never drops without a transfer, except on reset.
- Reset mid-burst: the remaining beats are discarded, prev clears to 0, and the next burst ramps from 0.
- Changing factor mid-burst has no effect until the next accept.

## Configuration
- LINEAR_INTERPOLATOR_ROUND_EN defined: output_data = (acc + 32) >>> 6, i.e. round to nearest, ties toward +inf. Beat L is still exact.
- Undefined: truncation (acc >>> 6).

## Structure
- package_settings holds:
  - SIZE_DATA, SIZE_WINDOW.
  - SIZE_FRAC=6.
  - SIZE_MAX_FACTOR=64.
  - typedef enum logic {IDLE, RUN} interp_state_t.
- One sub-module, interp_factor_decode: combinational factor -> {k[2:0], legal}, mapping illegal values to k=0.

## Test plan
- Ramp: after reset, L=4, x=8 then x=0, output_ready=1 -> beats 2,4,6,8 then 6,4,2,0; input_ready low for 3 cycles per burst.
- Negative and rounding: after reset, L=2, x=-3 -> truncation build gives -2,-3; with LINEAR_INTERPOLATOR_ROUND_EN gives -1,-3.
- Throughput: L=1, input_valid=1 with x=1..10 and output_ready=1 -> outputs 1..10 on 10 consecutive cycles, input_ready held 1.
- Backpressure: L=8, x=64 from 0, output_ready toggled 1,0,0,1,... -> sequence 8,16,...,64 exact with no duplicates or skips, and data stable while stalled.
- Illegal factor: factor=3, x=5 then factor=0, x=7 -> single beats 5, then 7.
- Reset mid-burst: L=64, x=640, reset asserted after 10 beats -> outputs 0/invalid next cycle. A following x=64 with L=64 -> beats 1,2,...,64.
